// File: rtl/csr_pkg.sv
// Shared definitions for the CSR trap sequencer: CSR addresses, interrupt cause
// codes, FSM state encoding and the mstatus/mtvec update helpers.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam logic [3:0] IRQ_CODE_MSI = 4'd3;
   localparam logic [3:0] IRQ_CODE_MTI = 4'd7;
   localparam logic [3:0] IRQ_CODE_MEI = 4'd11;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   typedef enum logic [2:0] {
      IDLE,
      T_EPC,
      T_CAUSE,
      T_TVAL,
      T_STAT,
      T_VEC,
      R_STAT,
      R_EPC
   } state_t;

   // Trap entry: stash MIE into MPIE and mask further interrupts.
   function automatic logic [31:0] mstatus_on_trap(input logic [31:0] rd);
      logic [31:0] v;
      v               = rd;
      v[MSTATUS_MPIE] = rd[MSTATUS_MIE];
      v[MSTATUS_MIE]  = 1'b0;
      return v;
   endfunction

   function automatic logic [31:0] mstatus_on_mret(input logic [31:0] rd);
      logic [31:0] v;
      v               = rd;
      v[MSTATUS_MIE]  = rd[MSTATUS_MPIE];
      v[MSTATUS_MPIE] = 1'b1;
      return v;
   endfunction

   function automatic logic [31:0] vector_base(input logic [31:0] mtvec);
      return {mtvec[31:2], 2'b00};
   endfunction

   // Vectored mode (mtvec[1:0]=1) offsets interrupts by 4*code from the base.
   function automatic logic [31:0] vector_target(input logic [31:0] mtvec,
                                                 input logic [3:0]  code);
      if (mtvec[1:0] == 2'b01)
         return vector_base(mtvec) + {26'd0, code, 2'b00};
      return vector_base(mtvec);
   endfunction

endpackage

// File: rtl/csr_irq_prio.sv
// Fixed-priority interrupt encoder: MEI over MSI over MTI, yields valid + cause code.
module csr_irq_prio
   import csr_pkg::*;
(
   input  logic       irq_meip,
   input  logic       irq_msip,
   input  logic       irq_mtip,
   output logic       irq_valid,
   output logic [3:0] irq_code
);

   always_comb begin
      irq_valid = irq_meip | irq_msip | irq_mtip;
      irq_code  = 4'd0;
      if (irq_meip)
         irq_code = IRQ_CODE_MEI;
      else if (irq_msip)
         irq_code = IRQ_CODE_MSI;
      else if (irq_mtip)
         irq_code = IRQ_CODE_MTI;
   end

endmodule

// File: rtl/csr_trap_seq.sv
// Machine-mode trap/mret sequencer sharing one CSR file port with instruction accesses.
// Define CSR_TRAP_VECTORED_EN to enable vectored interrupt dispatch (mtvec[1:0]=1).
module csr_trap_seq
   import csr_pkg::*;
(
   input  logic        ctrl_clk,
   input  logic        ctrl_reset_n,
   input  logic        ins_req,
   input  logic        ins_wen,
   input  logic [11:0] ins_addr,
   input  logic [31:0] ins_wdata,
   output logic        ins_gnt,
   output logic [31:0] ins_rdata,
   input  logic        exc_valid,
   input  logic [3:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic [31:0] exc_tval,
   output logic        exc_ack,
   input  logic        mret_valid,
   output logic        mret_ack,
   input  logic        irq_meip,
   input  logic        irq_msip,
   input  logic        irq_mtip,
   input  logic        ctrl_mie,
   output logic [11:0] csr_addr,
   output logic [31:0] csr_wdata,
   output logic        csr_wen,
   input  logic [31:0] csr_rdata,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        busy
);

   state_t      state_q, state_d;
   logic [31:0] pc_q, cause_q, tval_q, redirect_pc_q;
   logic [31:0] cause_d, tval_d, redirect_tgt;
   logic        irq_valid;
   logic [3:0]  irq_code;
   logic        trap_take;

   csr_irq_prio u_irq_prio (
      .irq_meip  (irq_meip),
      .irq_msip  (irq_msip),
      .irq_mtip  (irq_mtip),
      .irq_valid (irq_valid),
      .irq_code  (irq_code)
   );

   // Every output is forced idle while reset is asserted, even combinational ones.
   always_comb begin
      state_d      = state_q;
      exc_ack      = 1'b0;
      mret_ack     = 1'b0;
      ins_gnt      = 1'b0;
      csr_addr     = 12'd0;
      csr_wdata    = 32'd0;
      csr_wen      = 1'b0;
      redirect     = 1'b0;
      redirect_tgt = redirect_pc_q;
      trap_take    = 1'b0;
      cause_d      = {1'b1, 27'd0, irq_code};
      tval_d       = 32'd0;
      if (ctrl_reset_n) begin
         unique case (state_q)
            IDLE: begin
               if (exc_valid) begin
                  exc_ack   = 1'b1;
                  trap_take = 1'b1;
                  cause_d   = {28'd0, exc_cause};
                  tval_d    = exc_tval;
                  state_d   = T_EPC;
               end else if (mret_valid) begin
                  mret_ack = 1'b1;
                  state_d  = R_STAT;
               end else if (ctrl_mie && irq_valid) begin
                  trap_take = 1'b1;
                  state_d   = T_EPC;
               end else if (ins_req) begin
                  ins_gnt   = 1'b1;
                  csr_addr  = ins_addr;
                  csr_wdata = ins_wdata;
                  csr_wen   = ins_wen;
               end
            end
            T_EPC: begin
               csr_addr  = CSR_MEPC;
               csr_wdata = pc_q;
               csr_wen   = 1'b1;
               state_d   = T_CAUSE;
            end
            T_CAUSE: begin
               csr_addr  = CSR_MCAUSE;
               csr_wdata = cause_q;
               csr_wen   = 1'b1;
               state_d   = T_TVAL;
            end
            T_TVAL: begin
               csr_addr  = CSR_MTVAL;
               csr_wdata = tval_q;
               csr_wen   = 1'b1;
               state_d   = T_STAT;
            end
            T_STAT: begin
               csr_addr  = CSR_MSTATUS;
               csr_wdata = mstatus_on_trap(csr_rdata);
               csr_wen   = 1'b1;
               state_d   = T_VEC;
            end
            T_VEC: begin
               csr_addr = CSR_MTVEC;
               redirect = 1'b1;
`ifdef CSR_TRAP_VECTORED_EN
               if (cause_q[31])
                  redirect_tgt = vector_target(csr_rdata, cause_q[3:0]);
               else
                  redirect_tgt = vector_base(csr_rdata);
`else
               redirect_tgt = vector_base(csr_rdata);
`endif
               state_d = IDLE;
            end
            R_STAT: begin
               csr_addr  = CSR_MSTATUS;
               csr_wdata = mstatus_on_mret(csr_rdata);
               csr_wen   = 1'b1;
               state_d   = R_EPC;
            end
            R_EPC: begin
               csr_addr     = CSR_MEPC;
               redirect     = 1'b1;
               redirect_tgt = {csr_rdata[31:2], 2'b00};
               state_d      = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge ctrl_clk or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state_q       <= IDLE;
         pc_q          <= 32'd0;
         cause_q       <= 32'd0;
         tval_q        <= 32'd0;
         redirect_pc_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (trap_take) begin
            pc_q    <= exc_pc;
            cause_q <= cause_d;
            tval_q  <= tval_d;
         end
         if (redirect)
            redirect_pc_q <= redirect_tgt;
      end
   end

   assign ins_rdata   = csr_rdata;
   assign busy        = (state_q != IDLE);
   assign redirect_pc = redirect ? redirect_tgt : redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_seq.sv
// Randomized/directed bench for csr_trap_seq with a behavioural CSR file and trap model.
module tb_csr_trap_seq;

`ifdef CSR_TRAP_VECTORED_EN
   localparam bit VEC_EN = 1'b1;
`else
   localparam bit VEC_EN = 1'b0;
`endif

   logic        ctrl_clk = 1'b0;
   logic        ctrl_reset_n;
   logic        ins_req, ins_wen, ins_gnt;
   logic [11:0] ins_addr;
   logic [31:0] ins_wdata, ins_rdata;
   logic        exc_valid, exc_ack;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc, exc_tval;
   logic        mret_valid, mret_ack;
   logic        irq_meip, irq_msip, irq_mtip, ctrl_mie;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata, csr_rdata;
   logic        csr_wen;
   logic        redirect, busy;
   logic [31:0] redirect_pc;

   int compared   = 0;
   int mismatched = 0;

   // Behavioural CSR file owned by the bench.
   logic [31:0] m_status, m_epc, m_cause, m_tval, m_tvec;

   always #5 ctrl_clk = ~ctrl_clk;

   csr_trap_seq dut (
      .ctrl_clk     (ctrl_clk),
      .ctrl_reset_n (ctrl_reset_n),
      .ins_req      (ins_req),
      .ins_wen      (ins_wen),
      .ins_addr     (ins_addr),
      .ins_wdata    (ins_wdata),
      .ins_gnt      (ins_gnt),
      .ins_rdata    (ins_rdata),
      .exc_valid    (exc_valid),
      .exc_cause    (exc_cause),
      .exc_pc       (exc_pc),
      .exc_tval     (exc_tval),
      .exc_ack      (exc_ack),
      .mret_valid   (mret_valid),
      .mret_ack     (mret_ack),
      .irq_meip     (irq_meip),
      .irq_msip     (irq_msip),
      .irq_mtip     (irq_mtip),
      .ctrl_mie     (ctrl_mie),
      .csr_addr     (csr_addr),
      .csr_wdata    (csr_wdata),
      .csr_wen      (csr_wen),
      .csr_rdata    (csr_rdata),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .busy         (busy)
   );

   always_comb begin
      case (csr_addr)
         12'h300: csr_rdata = m_status;
         12'h305: csr_rdata = m_tvec;
         12'h341: csr_rdata = m_epc;
         12'h342: csr_rdata = m_cause;
         12'h343: csr_rdata = m_tval;
         default: csr_rdata = {20'hA5A5A, csr_addr};
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic half();
      @(negedge ctrl_clk);
   endtask

   // Commit any CSR write seen on the port, then advance to just after the edge.
   task automatic tick();
      if (csr_wen) begin
         case (csr_addr)
            12'h300: m_status = csr_wdata;
            12'h305: m_tvec   = csr_wdata;
            12'h341: m_epc    = csr_wdata;
            12'h342: m_cause  = csr_wdata;
            12'h343: m_tval   = csr_wdata;
            default: ;
         endcase
      end
      @(posedge ctrl_clk);
      #1;
   endtask

   task automatic do_trap(input bit irq, input logic [2:0] lines, input logic [3:0] cause,
                          input logic [31:0] pc, input logic [31:0] tval, input bit noise);
      logic [3:0]  code;
      logic [31:0] exp_cause, exp_tval, exp_ms, tgt, r;
      logic [11:0] exp_addr [4];
      logic [31:0] exp_data [4];
      if (irq) code = lines[2] ? 4'd11 : (lines[1] ? 4'd3 : 4'd7);
      else     code = cause;
      exp_cause = irq ? (32'h8000_0000 | 32'(code)) : 32'(code);
      exp_tval  = irq ? 32'd0 : tval;
      exp_ms    = m_status;
      exp_ms[7] = m_status[3];
      exp_ms[3] = 1'b0;
      tgt = m_tvec & 32'hFFFF_FFFC;
      if (VEC_EN && irq && m_tvec[1:0] == 2'b01) tgt = tgt + 4 * 32'(code);
      exp_addr = '{12'h341, 12'h342, 12'h343, 12'h300};
      exp_data = '{pc, exp_cause, exp_tval, exp_ms};

      exc_cause = cause;
      exc_pc    = pc;
      exc_tval  = tval;
      if (irq) begin
         ctrl_mie = 1'b1;
         {irq_meip, irq_msip, irq_mtip} = lines;
      end else begin
         exc_valid = 1'b1;
      end
      if (noise) begin
         r = $urandom;
         ins_req  = r[0];
         ins_addr = 12'h7C0;
      end
      half();
      chk("accept_exc_ack", exc_ack, !irq);
      chk("accept_mret_ack", mret_ack, 0);
      chk("accept_ins_gnt", ins_gnt, 0);
      chk("accept_busy", busy, 0);
      chk("accept_redirect", redirect, 0);
      tick();
      exc_valid = 1'b0;
      exc_pc    = $urandom;
      exc_tval  = $urandom;
      if (noise) begin
         r = $urandom;
         {irq_meip, irq_msip, irq_mtip} = r[2:0];
         ctrl_mie = r[3];
         ins_req  = r[4];
      end else begin
         {irq_meip, irq_msip, irq_mtip} = 3'b000;
      end
      for (int k = 0; k < 4; k++) begin
         half();
         chk("wr_busy", busy, 1);
         chk("wr_wen", csr_wen, 1);
         chk("wr_addr", csr_addr, exp_addr[k]);
         chk("wr_data", csr_wdata, exp_data[k]);
         chk("wr_redirect", redirect, 0);
         chk("wr_acks", {exc_ack, mret_ack, ins_gnt}, 0);
         if (k == 3) begin
            {irq_meip, irq_msip, irq_mtip} = 3'b000;
            ctrl_mie = 1'b0;
            if (noise) ins_req = 1'b0;
         end
         tick();
      end
      half();
      chk("vec_redirect", redirect, 1);
      chk("vec_redirect_pc", redirect_pc, tgt);
      chk("vec_wen", csr_wen, 0);
      chk("vec_addr", csr_addr, 12'h305);
      chk("vec_busy", busy, 1);
      tick();
      chk("mepc", m_epc, pc);
      chk("mcause", m_cause, exp_cause);
      chk("mtval", m_tval, exp_tval);
      chk("mstatus_trap", m_status, exp_ms);
   endtask

   task automatic do_mret();
      logic [31:0] exp_ms, tgt;
      exp_ms    = m_status;
      exp_ms[3] = m_status[7];
      exp_ms[7] = 1'b1;
      tgt       = m_epc & 32'hFFFF_FFFC;
      mret_valid = 1'b1;
      half();
      chk("mret_ack", mret_ack, 1);
      chk("mret_exc_ack", exc_ack, 0);
      chk("mret_ins_gnt", ins_gnt, 0);
      chk("mret_busy0", busy, 0);
      tick();
      mret_valid = 1'b0;
      half();
      chk("rstat_busy", busy, 1);
      chk("rstat_wen", csr_wen, 1);
      chk("rstat_addr", csr_addr, 12'h300);
      chk("rstat_data", csr_wdata, exp_ms);
      chk("rstat_redirect", redirect, 0);
      chk("rstat_acks", {exc_ack, mret_ack, ins_gnt}, 0);
      tick();
      half();
      chk("repc_redirect", redirect, 1);
      chk("repc_redirect_pc", redirect_pc, tgt);
      chk("repc_wen", csr_wen, 0);
      chk("repc_addr", csr_addr, 12'h341);
      chk("repc_ins_gnt", ins_gnt, 0);
      tick();
      chk("mstatus_mret", m_status, exp_ms);
   endtask

   task automatic do_ins(input logic [11:0] addr, input logic wen, input logic [31:0] wdata);
      ins_req   = 1'b1;
      ins_addr  = addr;
      ins_wen   = wen;
      ins_wdata = wdata;
      half();
      chk("ins_gnt", ins_gnt, 1);
      chk("ins_csr_addr", csr_addr, addr);
      chk("ins_csr_wen", csr_wen, wen);
      chk("ins_csr_wdata", csr_wdata, wdata);
      chk("ins_rdata", ins_rdata, {20'hA5A5A, addr});
      chk("ins_busy", busy, 0);
      tick();
      ins_req = 1'b0;
      ins_wen = 1'b0;
   endtask

   task automatic idle_check(input logic [31:0] hold_pc);
      half();
      chk("idle_busy", busy, 0);
      chk("idle_redirect", redirect, 0);
      chk("idle_wen", csr_wen, 0);
      chk("idle_redirect_pc_hold", redirect_pc, hold_pc);
      tick();
   endtask

   initial begin
      logic [31:0] r, r2;
      ctrl_reset_n = 1'b0;
      ins_req = 0; ins_wen = 0; ins_addr = '0; ins_wdata = '0;
      exc_valid = 0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
      mret_valid = 0; irq_meip = 0; irq_msip = 0; irq_mtip = 0; ctrl_mie = 0;
      m_status = 0; m_epc = 0; m_cause = 0; m_tval = 0; m_tvec = 0;

      // Reset state, with a pending exception that must not be acknowledged.
      exc_valid = 1'b1;
      repeat (2) @(posedge ctrl_clk);
      #1;
      half();
      chk("rst_busy", busy, 0);
      chk("rst_exc_ack", exc_ack, 0);
      chk("rst_redirect", redirect, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_wen", csr_wen, 0);
      exc_valid    = 1'b0;
      ctrl_reset_n = 1'b1;
      tick();

      // Synchronous exception.
      m_tvec   = 32'h2000;
      m_status = 32'h0000_0008;
      do_trap(1'b0, 3'b000, 4'd2, 32'h100, 32'hdead, 1'b0);
      idle_check(32'h2000);

      // Interrupt MTI+MEI with vectored mtvec.
      m_tvec = 32'h2001;
      do_trap(1'b1, 3'b101, 4'd0, 32'h5554, 32'h1234, 1'b0);
      chk("irq_mcause_const", m_cause, 32'h8000_000B);
      idle_check(VEC_EN ? 32'h202C : 32'h2000);

      // Masked interrupt is not taken.
      ctrl_mie = 1'b0;
      {irq_meip, irq_msip, irq_mtip} = 3'b111;
      half();
      chk("masked_busy", busy, 0);
      chk("masked_wen", csr_wen, 0);
      tick();
      half();
      chk("masked_busy2", busy, 0);
      tick();
      {irq_meip, irq_msip, irq_mtip} = 3'b000;

      // mret restores MIE from MPIE.
      m_epc    = 32'h400;
      m_status = 32'h0000_0080;
      do_mret();
      chk("mret_mstatus_const", m_status, 32'h0000_0088);
      idle_check(32'h400);

      // Simultaneous exception, mret and instruction access.
      m_tvec     = 32'h3000;
      mret_valid = 1'b1;
      ins_req    = 1'b1;
      ins_addr   = 12'h7C5;
      ins_wen    = 1'b1;
      ins_wdata  = 32'hCAFE_F00D;
      do_trap(1'b0, 3'b000, 4'd5, 32'h800, 32'h77, 1'b0);
      do_mret();
      do_ins(12'h7C5, 1'b1, 32'hCAFE_F00D);

      // Reset during T_CAUSE abandons the sequence.
      m_tvec    = 32'h4000;
      exc_valid = 1'b1;
      exc_cause = 4'd4;
      exc_pc    = 32'h900;
      half();
      chk("rst_seq_ack", exc_ack, 1);
      tick();
      exc_valid = 1'b0;
      half();
      tick();
      half();
      chk("rst_seq_tcause_wen", csr_wen, 1);
      #2 ctrl_reset_n = 1'b0;
      #1;
      chk("rst_seq_wen_drop", csr_wen, 0);
      chk("rst_seq_busy", busy, 0);
      chk("rst_seq_redirect_pc", redirect_pc, 0);
      tick();
      ctrl_reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         half();
         chk("post_rst_busy", busy, 0);
         chk("post_rst_redirect", redirect, 0);
         chk("post_rst_wen", csr_wen, 0);
         tick();
      end

      // Randomized transactions against the reference model.
      for (int n = 0; n < 150; n++) begin
         r  = $urandom;
         r2 = $urandom;
         m_status = $urandom;
         m_epc    = $urandom;
         m_tvec   = {r2[31:2], 1'b0, r[8]};
         case ($urandom_range(0, 4))
            0: do_trap(1'b0, 3'b000, r[3:0], $urandom, $urandom, r[9]);
            1: do_trap(1'b1, (r[6:4] == 3'b000) ? 3'b001 : r[6:4], r[3:0], $urandom, $urandom, r[9]);
            2: do_mret();
            3: do_ins({6'b011111, r[5:0]}, r[6], $urandom);
            default: begin
               ctrl_mie = 1'b0;
               {irq_meip, irq_msip, irq_mtip} = (r[2:0] == 3'b000) ? 3'b010 : r[2:0];
               half();
               chk("rnd_masked_busy", busy, 0);
               chk("rnd_masked_wen", csr_wen, 0);
               tick();
               {irq_meip, irq_msip, irq_mtip} = 3'b000;
            end
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
